// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C slave blocks: FSM encoding,
// ACK/NACK bus levels and counter-width helpers.
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_DATA,
    ST_DATA_ACK,
    ST_IGNORE
  } state_e;

  localparam logic ACK      = 1'b0;
  localparam logic NACK     = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  // Width able to hold 0..n inclusive.
  function automatic int unsigned cnt_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  // Width able to index n slots; never zero so a 1-entry buffer still has a port.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/i2c_slave_rx_if.sv
// Open-drain I2C pad bundle: raw SCL/SDA in, SDA pull-down request out.
interface i2c_slave_rx_if;
  logic SCL;
  logic SDA;
  logic SDA_down;

  modport slave  (input SCL, input SDA, output SDA_down);
  modport master (output SCL, output SDA, input SDA_down);
endinterface

// File: rtl/i2c_line_sync.sv
// Synchronises raw SCL/SDA into the FPGA clock domain and flags SCL edges
// plus START/STOP conditions, one registered cycle after synchronisation.
module i2c_line_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_raw,
  input  logic sda_raw,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
  logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
  logic scl_prev_q, scl_prev_d;
  logic sda_prev_q, sda_prev_d;
  logic scl_rise_q, scl_rise_d;
  logic scl_fall_q, scl_fall_d;
  logic start_q, start_d;
  logic stop_q, stop_d;
  logic scl_now, sda_now;

  always_comb begin
    scl_now    = scl_sync_q[SYNC_STAGES-1];
    sda_now    = sda_sync_q[SYNC_STAGES-1];
    scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_raw};
    sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_raw};
    scl_prev_d = scl_now;
    sda_prev_d = sda_now;
    scl_rise_d = scl_now & ~scl_prev_q;
    scl_fall_d = ~scl_now & scl_prev_q;
    start_d    = scl_now & scl_prev_q & sda_prev_q & ~sda_now;
    stop_d     = scl_now & scl_prev_q & ~sda_prev_q & sda_now;
  end

  // Idle bus level is high, so reset the synchronisers to 1 to avoid false edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
      scl_rise_q <= 1'b0;
      scl_fall_q <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_prev_q <= scl_prev_d;
      sda_prev_q <= sda_prev_d;
      scl_rise_q <= scl_rise_d;
      scl_fall_q <= scl_fall_d;
      start_q    <= start_d;
      stop_q     <= stop_d;
    end
  end

  // sda_prev_q is the sample aligned with the registered edge flags.
  assign sda_s    = sda_prev_q;
  assign scl_rise = scl_rise_q;
  assign scl_fall = scl_fall_q;
  assign start    = start_q;
  assign stop     = stop_q;

endmodule

// File: rtl/i2c_slave_rx.sv
// I2C write-only slave receiver: address match, ACK/NACK generation and a
// NUM_BYTES receive buffer with per-byte strobe and low-nibble display outputs.
module i2c_slave_rx
  import i2c_pkg::*;
#(
  parameter int unsigned NUM_BYTES   = 6,
  parameter logic [6:0]  SLAVE_ADDR  = 7'h42,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                              FPGA_clk,
  input  logic                              rst,
  input  logic                              enable,
  i2c_slave_rx_if.slave                     bus,
  output logic                              byte_valid,
  output logic [7:0]                        byte_data,
  output logic [idx_w(NUM_BYTES)-1:0]       byte_index,
  output logic [cnt_w(NUM_BYTES)-1:0]       byte_count,
  output logic                              addr_match,
  output logic                              overflow,
  output logic                              done,
  output logic [NUM_BYTES-1:0][3:0]         HEX_out
);

  localparam int unsigned CNT_W = cnt_w(NUM_BYTES);
  localparam int unsigned IDX_W = idx_w(NUM_BYTES);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(NUM_BYTES);

  logic sda_s, scl_rise, scl_fall, start, stop;

  i2c_line_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_line_sync (
    .clk      (FPGA_clk),
    .rst_n    (rst),
    .scl_raw  (bus.SCL),
    .sda_raw  (bus.SDA),
    .sda_s    (sda_s),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (start),
    .stop     (stop)
  );

  state_e                   state_q, state_d;
  logic [2:0]               bit_cnt_q, bit_cnt_d;
  logic [7:0]               shift_q, shift_d;
  logic                     phase_q, phase_d;
  logic                     ack_bit_q, ack_bit_d;
  logic                     sda_down_q, sda_down_d;
  logic                     addr_match_q, addr_match_d;
  logic                     overflow_q, overflow_d;
  logic                     done_q, done_d;
  logic                     byte_valid_q, byte_valid_d;
  logic [7:0]               byte_data_q, byte_data_d;
  logic [IDX_W-1:0]         byte_index_q, byte_index_d;
  logic [CNT_W-1:0]         byte_count_q, byte_count_d;
  logic [NUM_BYTES-1:0][3:0] hex_q, hex_d;
  logic [7:0]               buf_q [NUM_BYTES];
  logic [7:0]               buf_d [NUM_BYTES];

  logic [7:0]       shifted;
  logic             byte_done;
  logic             addr_hit;
  logic             room;
  logic [IDX_W-1:0] slot;

  always_comb begin
    shifted   = {shift_q[6:0], sda_s};
    byte_done = scl_rise && (bit_cnt_q == 3'd7);
    addr_hit  = (shifted[7:1] == SLAVE_ADDR) && (shifted[0] == RW_WRITE);
    room      = byte_count_q < FULL;
    slot      = IDX_W'(byte_count_q);
  end

  always_ff @(posedge FPGA_clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      phase_q      <= 1'b0;
      ack_bit_q    <= NACK;
      sda_down_q   <= 1'b0;
      addr_match_q <= 1'b0;
      overflow_q   <= 1'b0;
      done_q       <= 1'b0;
      byte_valid_q <= 1'b0;
      byte_data_q  <= '0;
      byte_index_q <= '0;
      byte_count_q <= '0;
      hex_q        <= '0;
      buf_q        <= '{default: '0};
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      phase_q      <= phase_d;
      ack_bit_q    <= ack_bit_d;
      sda_down_q   <= sda_down_d;
      addr_match_q <= addr_match_d;
      overflow_q   <= overflow_d;
      done_q       <= done_d;
      byte_valid_q <= byte_valid_d;
      byte_data_q  <= byte_data_d;
      byte_index_q <= byte_index_d;
      byte_count_q <= byte_count_d;
      hex_q        <= hex_d;
      buf_q        <= buf_d;
    end
  end

  // Stop outranks start so a same-cycle collision always lands in IDLE.
  always_comb begin
    state_d = state_q;
    if (!enable || stop) begin
      state_d = ST_IDLE;
    end else if (start) begin
      state_d = ST_ADDR;
    end else begin
      unique case (state_q)
        ST_ADDR:     if (byte_done) state_d = addr_hit ? ST_ADDR_ACK : ST_IGNORE;
        ST_DATA:     if (byte_done) state_d = ST_DATA_ACK;
        ST_ADDR_ACK,
        ST_DATA_ACK: if (scl_fall && phase_q) state_d = (ack_bit_q == ACK) ? ST_DATA : ST_IGNORE;
        default:     state_d = state_q;
      endcase
    end
  end

  always_comb begin
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    phase_d      = phase_q;
    ack_bit_d    = ack_bit_q;
    sda_down_d   = sda_down_q;
    addr_match_d = addr_match_q;
    overflow_d   = overflow_q;
    done_d       = 1'b0;
    byte_valid_d = 1'b0;
    byte_data_d  = byte_data_q;
    byte_index_d = byte_index_q;
    byte_count_d = byte_count_q;
    hex_d        = hex_q;
    buf_d        = buf_q;

    if (!enable) begin
      sda_down_d   = 1'b0;
      addr_match_d = 1'b0;
      phase_d      = 1'b0;
    end else if (stop) begin
      sda_down_d   = 1'b0;
      addr_match_d = 1'b0;
      phase_d      = 1'b0;
      done_d       = (byte_count_q != '0);
    end else if (start) begin
      bit_cnt_d    = '0;
      byte_count_d = '0;
      overflow_d   = 1'b0;
      sda_down_d   = 1'b0;
      addr_match_d = 1'b0;
      phase_d      = 1'b0;
    end else begin
      unique case (state_q)
        ST_ADDR, ST_DATA: begin
          // bit_cnt wraps 7->0 on the last bit, so DATA always starts at bit 0.
          if (scl_rise) begin
            shift_d   = shifted;
            bit_cnt_d = bit_cnt_q + 3'd1;
            phase_d   = 1'b0;
            if (bit_cnt_q == 3'd7) begin
              if (state_q == ST_ADDR) begin
                ack_bit_d = addr_hit ? ACK : NACK;
              end else if (room) begin
                buf_d[slot]  = shifted;
                hex_d[slot]  = shifted[3:0];
                byte_data_d  = shifted;
                byte_index_d = slot;
                byte_valid_d = 1'b1;
                byte_count_d = byte_count_q + 1'b1;
                ack_bit_d    = ACK;
              end else begin
                overflow_d = 1'b1;
                ack_bit_d  = NACK;
              end
            end
          end
        end
        ST_ADDR_ACK, ST_DATA_ACK: begin
          if (scl_fall) begin
            if (!phase_q) begin
              sda_down_d = (ack_bit_q == ACK);
              phase_d    = 1'b1;
              if (state_q == ST_ADDR_ACK) addr_match_d = 1'b1;
            end else begin
              sda_down_d = 1'b0;
              phase_d    = 1'b0;
            end
          end
        end
        default: sda_down_d = 1'b0;
      endcase
    end
  end

  assign bus.SDA_down = sda_down_q & enable;
  assign byte_valid   = byte_valid_q;
  assign byte_data    = byte_data_q;
  assign byte_index   = byte_index_q;
  assign byte_count   = byte_count_q;
  assign addr_match   = addr_match_q;
  assign overflow     = overflow_q;
  assign done         = done_q;
  assign HEX_out      = hex_q;

endmodule

// File: tb/tb_i2c_slave_rx.sv
// Scoreboard bench for i2c_slave_rx: an I2C master model drives the bus,
// expected byte/done events are queued and checked by a separate monitor.
module tb_i2c_slave_rx;
  import i2c_pkg::*;

  localparam int unsigned NB = 6;
  localparam int H = 160;
  localparam int Q = 80;

  logic clk = 1'b0;
  logic rst_n;
  logic enable;
  logic m_scl = 1'b1;
  logic m_sda = 1'b1;

  logic              byte_valid;
  logic [7:0]        byte_data;
  logic [2:0]        byte_index;
  logic [2:0]        byte_count;
  logic              addr_match;
  logic              overflow;
  logic              done;
  logic [NB-1:0][3:0] hex_out;

  i2c_slave_rx_if bus();
  assign bus.SCL = m_scl;
  assign bus.SDA = m_sda & ~bus.SDA_down;

  i2c_slave_rx #(
    .NUM_BYTES(NB),
    .SLAVE_ADDR(7'h42),
    .SYNC_STAGES(2)
  ) dut (
    .FPGA_clk   (clk),
    .rst        (rst_n),
    .enable     (enable),
    .bus        (bus),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_index (byte_index),
    .byte_count (byte_count),
    .addr_match (addr_match),
    .overflow   (overflow),
    .done       (done),
    .HEX_out    (hex_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int sda_rises = 0;
  logic sda_down_prev = 1'b0;
  logic [10:0] exp_byte_q[$];
  int          exp_done_q[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Monitor: pops expected events whenever the DUT presents one.
  always @(negedge clk) begin
    logic [10:0] e;
    int ec;
    if (byte_valid === 1'b1) begin
      if (exp_byte_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_byte_valid: got data %0h index %0h expected none", byte_data, byte_index);
      end else begin
        e = exp_byte_q.pop_front();
        chk("byte_data", {24'd0, byte_data}, {24'd0, e[7:0]});
        chk("byte_index", {29'd0, byte_index}, {29'd0, e[10:8]});
      end
    end
    if (done === 1'b1) begin
      if (exp_done_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done: got count %0d expected no done", byte_count);
      end else begin
        ec = exp_done_q.pop_front();
        chk("done_byte_count", {29'd0, byte_count}, ec);
      end
    end
    if (bus.SDA_down !== sda_down_prev) begin
      chk("sda_down_change_scl_low", {31'd0, bus.SCL}, 0);
      if (bus.SDA_down === 1'b1) sda_rises++;
    end
    sda_down_prev = bus.SDA_down;
  end

  task automatic i2c_start();
    m_sda = 1'b1; #Q; m_scl = 1'b1; #Q; m_sda = 1'b0; #Q; m_scl = 1'b0; #Q;
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; #Q; m_scl = 1'b1; #Q; m_sda = 1'b1; #H;
  endtask

  task automatic send_bit(input logic b);
    m_sda = b; #Q; m_scl = 1'b1; #H; m_scl = 1'b0; #Q;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic ack_slot(input string name, input logic exp);
    logic got;
    m_sda = 1'b1; #Q; m_scl = 1'b1; #(H/2);
    got = bus.SDA;
    #(H/2); m_scl = 1'b0; #Q;
    chk(name, {31'd0, got}, {31'd0, exp});
  endtask

  task automatic write_byte(input string name, input logic [7:0] b, input logic exp_ack);
    send_byte(b);
    ack_slot(name, exp_ack);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_byte_valid"}, {31'd0, byte_valid}, 0);
    chk({tag, "_byte_data"}, {24'd0, byte_data}, 0);
    chk({tag, "_byte_index"}, {29'd0, byte_index}, 0);
    chk({tag, "_byte_count"}, {29'd0, byte_count}, 0);
    chk({tag, "_addr_match"}, {31'd0, addr_match}, 0);
    chk({tag, "_overflow"}, {31'd0, overflow}, 0);
    chk({tag, "_done"}, {31'd0, done}, 0);
    chk({tag, "_hex_out"}, {8'd0, hex_out}, 0);
    chk({tag, "_sda_down"}, {31'd0, bus.SDA_down}, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int rises0;
    rst_n  = 1'b0;
    enable = 1'b1;
    #1;
    check_reset_outputs("reset");
    chk("reset_state", {29'd0, dut.state_q}, {29'd0, ST_IDLE});
    #100; rst_n = 1'b1; #100;

    // Basic write of one byte.
    i2c_start();
    write_byte("addr_ack_84", 8'h84, 1'b0);
    chk("addr_match_after_ack", {31'd0, addr_match}, 1);
    exp_byte_q.push_back({3'd0, 8'hA5});
    write_byte("data_ack_a5", 8'hA5, 1'b0);
    exp_done_q.push_back(1);
    i2c_stop();
    chk("t1_byte_count", {29'd0, byte_count}, 1);
    chk("t1_hex", {8'd0, hex_out}, 32'h000005);
    chk("t1_addr_match_cleared", {31'd0, addr_match}, 0);

    // Wrong address: no ACK, no data.
    rises0 = sda_rises;
    i2c_start();
    write_byte("wrong_addr_nack", 8'h86, 1'b1);
    write_byte("wrong_d0_nack", 8'h01, 1'b1);
    write_byte("wrong_d1_nack", 8'h02, 1'b1);
    write_byte("wrong_d2_nack", 8'h03, 1'b1);
    i2c_stop();
    chk("wrong_addr_no_sda_down", sda_rises - rises0, 0);

    // Read request is refused.
    i2c_start();
    write_byte("read_nack", 8'h85, 1'b1);
    chk("read_ignore_state", {29'd0, dut.state_q}, {29'd0, ST_IGNORE});
    chk("read_byte_count", {29'd0, byte_count}, 0);
    i2c_stop();

    // Overflow: 7 bytes into a 6-byte buffer.
    i2c_start();
    write_byte("ovf_addr_ack", 8'h84, 1'b0);
    for (int i = 0; i < 7; i++) begin
      if (i < 6) exp_byte_q.push_back({3'(i), 8'(8'h10 + i)});
      write_byte((i < 6) ? "ovf_data_ack" : "ovf_7th_nack", 8'(8'h10 + i), (i < 6) ? 1'b0 : 1'b1);
    end
    chk("ovf_overflow", {31'd0, overflow}, 1);
    chk("ovf_byte_count", {29'd0, byte_count}, 6);
    chk("ovf_hex", {8'd0, hex_out}, 32'h543210);
    exp_done_q.push_back(6);
    i2c_stop();
    chk("ovf_sticky_after_stop", {31'd0, overflow}, 1);

    // Repeated START rewinds to slot 0.
    i2c_start();
    write_byte("rs_addr_ack", 8'h84, 1'b0);
    chk("rs_overflow_cleared", {31'd0, overflow}, 0);
    exp_byte_q.push_back({3'd0, 8'h11});
    write_byte("rs_d0_ack", 8'h11, 1'b0);
    exp_byte_q.push_back({3'd1, 8'h22});
    write_byte("rs_d1_ack", 8'h22, 1'b0);
    i2c_start();
    write_byte("rs_addr2_ack", 8'h84, 1'b0);
    exp_byte_q.push_back({3'd0, 8'h3C});
    write_byte("rs_d2_ack", 8'h3C, 1'b0);
    exp_done_q.push_back(1);
    i2c_stop();
    chk("rs_byte_count", {29'd0, byte_count}, 1);
    chk("rs_hex", {8'd0, hex_out}, 32'h54322C);

    // Reset during the 4th bit of a data byte.
    i2c_start();
    write_byte("mr_addr_ack", 8'h84, 1'b0);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    m_sda = 1'b1; #Q; m_scl = 1'b1; #(H/2);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    m_scl = 1'b1; m_sda = 1'b1;
    #H; rst_n = 1'b1; #H;
    i2c_start();
    write_byte("mr2_addr_ack", 8'h84, 1'b0);
    exp_byte_q.push_back({3'd0, 8'h5A});
    write_byte("mr2_data_ack", 8'h5A, 1'b0);
    exp_done_q.push_back(1);
    i2c_stop();
    chk("mr2_hex", {8'd0, hex_out}, 32'h00000A);
    chk("mr2_byte_count", {29'd0, byte_count}, 1);

    // enable low during the address ACK releases SDA at once.
    i2c_start();
    send_byte(8'h84);
    chk("en_ack_driven", {31'd0, bus.SDA_down}, 1);
    enable = 1'b0;
    #1;
    chk("en_sda_released", {31'd0, bus.SDA_down}, 0);
    ack_slot("en_ack_slot_released", 1'b1);
    write_byte("en_data_ignored", 8'h77, 1'b1);
    enable = 1'b1;
    i2c_stop();
    chk("en_hex_retained", {8'd0, hex_out}, 32'h00000A);

    repeat (20) @(posedge clk);
    chk("byte_queue_empty", exp_byte_q.size(), 0);
    chk("done_queue_empty", exp_done_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
